dcsk_tx_ctrl: RTL

//  DCSK modulator controller: end of the link that feeds the demodulator FSM. Accepts one 32-bit data word.
//  Per data bit, emits Spread_Factor reference chips from the chaos generator, then the same chips again:

---
 rtl/dcsk_pkg.sv | 23 ++
 rtl/dcsk_if.sv | 21 ++
 rtl/dcsk_chip_buffer.sv | 22 ++
 rtl/dcsk_tx_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dcsk_pkg.sv
// Shared types, constants and helpers for the DCSK transmit controller.
package dcsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    INFO = 2'd2
  } tx_state_t;

  localparam int unsigned DCSK_DATA_W = 32;
  localparam int unsigned DCSK_MAX_SF = 16;
  localparam int unsigned DCSK_MIN_SF = 2;

  // Limit a requested spread factor to the range the chip buffer supports.
  function automatic logic [4:0] sf_clamp(input logic [4:0] sf, input logic [4:0] max_sf);
    logic [4:0] r;
    r = sf;
    if (sf < 5'(DCSK_MIN_SF)) r = 5'(DCSK_MIN_SF);
    else if (sf > max_sf)     r = max_sf;
    return r;
  endfunction

endpackage

// File: rtl/dcsk_if.sv
// Word-input handshake bundle for the DCSK transmit controller.
interface dcsk_if
  import dcsk_pkg::*;
#(
  parameter int unsigned DATA_W = DCSK_DATA_W
);
  logic [DATA_W-1:0] Data_In;
  logic              Data_In_Valid;
  logic              Data_In_Ready;
  logic [4:0]        Spread_Factor;

  modport master (
    output Data_In, Data_In_Valid, Spread_Factor,
    input  Data_In_Ready
  );

  modport slave (
    input  Data_In, Data_In_Valid, Spread_Factor,
    output Data_In_Ready
  );
endinterface

// File: rtl/dcsk_chip_buffer.sv
// Reference-chip store: one bit per chip of the current half-symbol.
module dcsk_chip_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     N_Rst,
  input  logic                     We,
  input  logic [$clog2(DEPTH)-1:0] Waddr,
  input  logic                     Wdata,
  input  logic [$clog2(DEPTH)-1:0] Raddr,
  output logic                     Rdata
);
  logic [DEPTH-1:0] mem;

  // Synchronous single-bit write, cleared by reset.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) mem <= '0;
    else if (We) mem[Waddr] <= Wdata;
  end

  assign Rdata = mem[Raddr];
endmodule

// File: rtl/dcsk_tx_ctrl.sv
// DCSK modulator controller: per data bit, sf reference chips from the chaos
// source followed by the same chips, inverted when the bit is 0.
// Optional build macro DCSK_TX_BACK2BACK_EN lets a new word be accepted on the
// last chip of a frame so consecutive frames stream without a Tx_Valid gap.
module dcsk_tx_ctrl
  import dcsk_pkg::*;
#(
  parameter int unsigned DATA_W = DCSK_DATA_W,
  parameter int unsigned MAX_SF = DCSK_MAX_SF
) (
  input  logic  Clk,
  input  logic  N_Rst,
  dcsk_if.slave Word_If,
  input  logic  Tx_Abort,
  input  logic  Chaos_Bit,
  output logic  Chaos_Req,
  output logic  Tx_Chip,
  output logic  Tx_Valid,
  output logic  Frame_Done,
  output logic  Busy
);
  localparam int unsigned AW   = $clog2(MAX_SF);
  localparam int unsigned BI_W = $clog2(DATA_W);
  localparam int unsigned SF_W = 5;

  tx_state_t         state;
  logic [SF_W-1:0]   sf_q;
  logic [DATA_W-1:0] word_q;
  logic [BI_W-1:0]   bit_idx;
  logic [AW-1:0]     chip_cnt;
  logic              tx_chip_q;
  logic              tx_valid_q;
  logic              frame_done_q;
  logic              buf_rdata;
  logic              last_chip;
  logic              last_bit;
  logic              ready_int;
  logic              accept;

  dcsk_chip_buffer #(.DEPTH(MAX_SF)) u_buf (
    .Clk   (Clk),
    .N_Rst (N_Rst),
    .We    (state == REF),
    .Waddr (chip_cnt),
    .Wdata (Chaos_Bit),
    .Raddr (chip_cnt),
    .Rdata (buf_rdata)
  );

  // Phase/frame boundary decode and input handshake.
  always_comb begin
    last_chip = (SF_W'(chip_cnt) == (sf_q - SF_W'(1)));
    last_bit  = (bit_idx == BI_W'(DATA_W - 1));
`ifdef DCSK_TX_BACK2BACK_EN
    ready_int = N_Rst && !Tx_Abort &&
                ((state == IDLE) || ((state == INFO) && last_chip && last_bit));
`else
    ready_int = N_Rst && !Tx_Abort && (state == IDLE);
`endif
    accept    = ready_int && Word_If.Data_In_Valid;
  end

  assign Word_If.Data_In_Ready = ready_int;
  assign Chaos_Req             = (state == REF);
  assign Busy                  = (state != IDLE);
  assign Tx_Chip               = tx_chip_q;
  assign Tx_Valid              = tx_valid_q;
  assign Frame_Done            = frame_done_q;

  // Frame sequencer: REF/INFO alternation per bit, word shift and output registers.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state        <= IDLE;
      sf_q         <= '0;
      word_q       <= '0;
      bit_idx      <= '0;
      chip_cnt     <= '0;
      tx_chip_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_chip_q  <= 1'b0;
          tx_valid_q <= 1'b0;
          if (accept) begin
            word_q   <= Word_If.Data_In;
            sf_q     <= sf_clamp(Word_If.Spread_Factor, SF_W'(MAX_SF));
            bit_idx  <= '0;
            chip_cnt <= '0;
            state    <= REF;
          end
        end
        REF: begin
          if (Tx_Abort) begin
            state      <= IDLE;
            tx_chip_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            bit_idx    <= '0;
            chip_cnt   <= '0;
          end else begin
            tx_chip_q  <= Chaos_Bit;
            tx_valid_q <= 1'b1;
            if (last_chip) begin
              chip_cnt <= '0;
              state    <= INFO;
            end else begin
              chip_cnt <= chip_cnt + 1'b1;
            end
          end
        end
        INFO: begin
          if (Tx_Abort) begin
            state      <= IDLE;
            tx_chip_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            bit_idx    <= '0;
            chip_cnt   <= '0;
          end else begin
            // word_q[0] is always the current bit: the word shifts right per bit
            tx_chip_q  <= buf_rdata ^ ~word_q[0];
            tx_valid_q <= 1'b1;
            if (last_chip) begin
              chip_cnt <= '0;
              if (last_bit) begin
                frame_done_q <= 1'b1;
                if (accept) begin
                  word_q  <= Word_If.Data_In;
                  sf_q    <= sf_clamp(Word_If.Spread_Factor, SF_W'(MAX_SF));
                  bit_idx <= '0;
                  state   <= REF;
                end else begin
                  bit_idx <= '0;
                  state   <= IDLE;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
                word_q  <= word_q >> 1;
                state   <= REF;
              end
            end else begin
              chip_cnt <= chip_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
